// File: rtl/serial_adder_256.sv
// serial_adder_256
//   Bit-serial ripple adder. A single full-adder cell and a carry flop add
//   two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
//   The final value is {cout, sum} == a + b + cin, computed in WIDTH+1 bits.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (low clears all state)
//   a, b  : operands, held stable from reset release until done
//   cin   : carry into bit 0, used only on the first edge after release
//   sum   : registered sum, filled LSB first; bits >= idx read 0
//   cout  : registered carry out of bit WIDTH-1, valid when done=1
//   done  : high once all WIDTH bits are processed, held until reset
//
// Handshake: there is no valid/ready pair. Each reset release starts one
// addition, and done is a sticky level. Once it is high, the outputs are
// final and every register is frozen until the next reset.

module serial_adder_256 #(
  parameter  int WIDTH = 256,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  logic [CNT_W-1:0] idx;
  logic [IDX_W-1:0] bit_idx;
  logic             carry;
  logic             c_in_bit;
  logic             s_bit;
  logic             co_bit;
  logic             last_bit;

  // idx never exceeds WIDTH-1 while work remains, so its low bits are a
  // valid bit position in the operands.
  assign bit_idx  = idx[IDX_W-1:0];
  assign last_bit = (idx == CNT_W'(WIDTH - 1));

  // Full-adder cell. Bit 0 takes its carry from cin; later bits use the
  // carry flop.
  always_comb begin
    c_in_bit = carry;
    s_bit    = 1'b0;
    co_bit   = 1'b0;
    if (idx == '0) begin
      c_in_bit = cin;
    end
    s_bit  = a[bit_idx] ^ b[bit_idx] ^ c_in_bit;
    co_bit = (a[bit_idx] & b[bit_idx]) |
             (a[bit_idx] & c_in_bit)   |
             (b[bit_idx] & c_in_bit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
    end else if (!done) begin
      sum[bit_idx] <= s_bit;
      carry        <= co_bit;
      idx          <= idx + CNT_W'(1);
      if (last_bit) begin
        cout <= co_bit;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_256.sv
// tb_serial_adder_256
//   Self-checking bench for serial_adder_256. It runs a table of operand
//   sets through full additions, with a scoreboard queue of expected
//   {cout, sum} values. Hand-written sequences cover a mid-run reset and
//   hold-after-done.

module tb_serial_adder_256;

  localparam int W = 256;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  serial_adder_256 #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .done (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Hold reset and load the operands, then check the cleared outputs.
  // Push the reference result and release reset at a falling edge, so the
  // next rising edge processes bit 0.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input logic [W:0] expv, input string name);
    rst = 1'b0;
    a   = va;
    b   = vb;
    cin = vc;
    #1;
    check({name, " reset"}, {cout, sum}, '0);
    check({name, " reset done"}, {{W{1'b0}}, done}, '0);
    exp_q.push_back(expv);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait the remaining edges. done must still be low after edge WIDTH-1
  // and high after edge WIDTH, when the scoreboard entry is popped.
  task automatic finish_op(input int edges_done, input string name);
    logic [W:0] expv;
    repeat (W - 1 - edges_done) @(posedge clk);
    #1;
    check({name, " done early"}, {{W{1'b0}}, done}, '0);
    @(posedge clk);
    #1;
    check({name, " done"}, {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty got %h expected entry", name, {cout, sum});
    end else begin
      expv = exp_q.pop_front();
      check({name, " result"}, {cout, sum}, expv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] alt;
    logic [W-1:0] mask;
    logic [W:0]   expv;
    logic [W:0]   peek;

    rst = 1'b0;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    ones = {W{1'b1}};
    alt  = {(W/2){2'b01}};
    ra   = rand_word256();
    rb   = rand_word256();

    repeat (2) @(posedge clk);

    // Fixed cases carry hand-written expected values. The random rows take
    // their reference from a + b + cin computed in W+1 bits.
    vecs[0] = '{'0,   '0,   1'b0, '0,              1'b0};
    vecs[1] = '{ones, '0,   1'b1, '0,              1'b1};
    vecs[2] = '{ones, ones, 1'b1, ones,            1'b1};
    vecs[3] = '{ones, ones, 1'b0, {ones[W-1:1], 1'b0}, 1'b1};
    vecs[4] = '{'0,   '0,   1'b1, W'(1),           1'b0};
    vecs[5] = '{alt,  ~alt, 1'b1, '0,              1'b1};
    vecs[6] = '{ra,   rb,   1'b0, '0,              1'b0};
    vecs[7] = '{ra,   rb,   1'b1, '0,              1'b0};
    for (int i = 6; i < 8; i++) begin
      expv = {1'b0, vecs[i].va} + {1'b0, vecs[i].vb} + (W+1)'(vecs[i].vc);
      vecs[i].exp_sum  = expv[W-1:0];
      vecs[i].exp_cout = expv[W];
    end

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vc, {vecs[i].exp_cout, vecs[i].exp_sum}, nm);
      finish_op(0, nm);
    end

    // Hold after done: new operands and 50 more edges must change nothing.
    a   = ~ra;
    b   = ~rb;
    cin = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("hold result", {cout, sum}, {vecs[7].exp_cout, vecs[7].exp_sum});
    check("hold done", {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});

    // Reset at cycle 100. The partial sum has bits 0..99 set and the rest
    // zero. The asynchronous clear lands between edges, and the restart
    // must produce the full result.
    ra   = rand_word256();
    rb   = rand_word256();
    expv = {1'b0, ra} + {1'b0, rb} + (W+1)'(1);
    start_op(ra, rb, 1'b1, expv, "midrst");
    repeat (100) @(posedge clk);
    #1;
    mask = (W'(1) << 100) - W'(1);
    peek = exp_q[0];
    check("midrst partial", {cout, sum}, {1'b0, peek[W-1:0] & mask});
    check("midrst partial done", {{W{1'b0}}, done}, '0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst async clear", {cout, sum}, '0);
    void'(exp_q.pop_front());
    start_op(ra, rb, 1'b1, expv, "midrst restart");
    finish_op(0, "midrst restart");

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
